// File: rtl/obstacle_lane.sv
// obstacle_lane: one horizontal car lane of the crossy-road playfield.
// The lane scrolls down by MOVE_AMT rows on each move_followers pulse. The car
// steps horizontally once per frame_tick. When the lane scrolls off the bottom,
// it returns to row 0 and the car respawns with a random speed and direction.
// obs_on is the registered beam-inside-car pixel flag. collision is sticky.
// Optional feature: define OBSTACLE_TWO_CARS_EN to add a second car half a
// screen away from the first. The second car shares lane_y, dir and speed.
//
// Pulse inputs: move_followers and frame_tick are single-cycle strobes with no
// back-pressure. Each cycle they are high counts as exactly one event. Both may
// be high in the same cycle, and each updates its own registers.
module obstacle_lane #(
  parameter int         Y_OFFSET  = 150,
  parameter int         MOVE_AMT  = 2,
  parameter int         SCREEN_W  = 640,
  parameter int         SCREEN_H  = 480,
  parameter int         CAR_W     = 32,
  parameter int         CAR_H     = 16,
  parameter int         PLAYER_SZ = 16,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       move_followers,
  input  logic       game_run,
  input  logic       frame_tick,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  output logic       obs_on,
  output logic       collision,
  output logic [9:0] lane_y
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HIT = 2'd2} state_t;

  // 11-bit constants so every sum of a 10-bit coordinate and a size stays exact
  localparam logic [10:0] SCR_W   = 11'(SCREEN_W);
  localparam logic [10:0] SCR_H   = 11'(SCREEN_H);
  localparam logic [10:0] CW      = 11'(CAR_W);
  localparam logic [10:0] CH      = 11'(CAR_H);
  localparam logic [10:0] PS      = 11'(PLAYER_SZ);
  localparam logic [10:0] MV      = 11'(MOVE_AMT);
  localparam logic [9:0]  SCR_W10 = 10'(SCREEN_W);
  localparam logic [9:0]  MV10    = 10'(MOVE_AMT);
  localparam logic [9:0]  RSP_L   = 10'(SCREEN_W - CAR_W);

  state_t      state_q, state_d;
  logic [9:0]  lane_y_q, lane_y_d;
  logic [9:0]  car_x_q, car_x_d;
  logic        dir_q, dir_d;
  logic [2:0]  speed_q, speed_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic        respawn_q, respawn_d;
  logic        obs_on_q, obs_on_d;
  logic        collision_q, collision_d;

  logic [10:0] car1_x, lane_ext, lane_sum, car_sum;
  logic        player_hit, beam_hit;

  // Axis-aligned overlap test between the player square and a car box.
  function automatic logic box_overlap(input logic [10:0] cx, input logic [10:0] ly,
                                       input logic [10:0] px, input logic [10:0] py);
    return (px < cx + CW) && (cx < px + PS) && (py < ly + CH) && (ly < py + PS);
  endfunction

  // Beam-inside-car test. Columns at or beyond the screen edge are clipped.
  function automatic logic beam_in(input logic [10:0] cx, input logic [10:0] ly,
                                   input logic [10:0] bx, input logic [10:0] by);
    return (bx >= cx) && (bx < cx + CW) && (bx < SCR_W) && (by >= ly) && (by < ly + CH);
  endfunction

  assign car1_x   = {1'b0, car_x_q};
  assign lane_ext = {1'b0, lane_y_q};
  assign lane_sum = lane_ext + MV;
  assign car_sum  = car1_x + {8'd0, speed_q};

`ifdef OBSTACLE_TWO_CARS_EN
  logic [10:0] car2_sum, car2_x;
  assign car2_sum   = car1_x + (SCR_W >> 1);
  assign car2_x     = (car2_sum >= SCR_W) ? car2_sum - SCR_W : car2_sum;
  assign player_hit = box_overlap(car1_x, lane_ext, {1'b0, player_x}, {1'b0, player_y}) ||
                      box_overlap(car2_x, lane_ext, {1'b0, player_x}, {1'b0, player_y});
  assign beam_hit   = beam_in(car1_x, lane_ext, {1'b0, pix_x}, {1'b0, pix_y}) ||
                      beam_in(car2_x, lane_ext, {1'b0, pix_x}, {1'b0, pix_y});
`else
  assign player_hit = box_overlap(car1_x, lane_ext, {1'b0, player_x}, {1'b0, player_y});
  assign beam_hit   = beam_in(car1_x, lane_ext, {1'b0, pix_x}, {1'b0, pix_y});
`endif

  // Next-state logic: FSM, scroll, respawn, horizontal motion and collision.
  always_comb begin
    state_d     = state_q;
    lane_y_d    = lane_y_q;
    car_x_d     = car_x_q;
    dir_d       = dir_q;
    speed_d     = speed_q;
    respawn_d   = respawn_q;
    collision_d = collision_q;
    lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    obs_on_d    = (state_q != IDLE) && beam_hit;

    case (state_q)
      IDLE: begin
        if (game_run) state_d = RUN;
      end
      RUN: begin
        // A respawn lands one cycle after the wrap. It overrides any frame step
        // that arrives in the same cycle.
        if (respawn_q) begin
          respawn_d = 1'b0;
          speed_d   = {1'b0, lfsr_q[1:0]} + 3'd1;
          dir_d     = lfsr_q[2];
          car_x_d   = lfsr_q[2] ? RSP_L : 10'd0;
        end else if (frame_tick) begin
          if (dir_q) begin
            if (car1_x < {8'd0, speed_q}) car_x_d = 10'(car_x_q + SCR_W10 - {7'd0, speed_q});
            else                          car_x_d = 10'(car_x_q - {7'd0, speed_q});
          end else begin
            if (car_sum >= SCR_W) car_x_d = 10'(car_x_q + {7'd0, speed_q} - SCR_W10);
            else                  car_x_d = 10'(car_x_q + {7'd0, speed_q});
          end
        end
        if (move_followers) begin
          if (lane_sum >= SCR_H) begin
            lane_y_d  = 10'd0;
            respawn_d = 1'b1;
          end else begin
            lane_y_d  = lane_y_q + MV10;
          end
        end
        // Collision uses the pre-update car and lane positions.
        if (frame_tick && player_hit) begin
          collision_d = 1'b1;
          state_d     = HIT;
        end else if (!game_run) begin
          state_d = IDLE;
        end
      end
      HIT: begin
        collision_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lane_y_q    <= 10'(Y_OFFSET);
      car_x_q     <= 10'd0;
      dir_q       <= 1'b0;
      speed_q     <= 3'd1;
      lfsr_q      <= LFSR_SEED;
      respawn_q   <= 1'b0;
      obs_on_q    <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_y_q    <= lane_y_d;
      car_x_q     <= car_x_d;
      dir_q       <= dir_d;
      speed_q     <= speed_d;
      lfsr_q      <= lfsr_d;
      respawn_q   <= respawn_d;
      obs_on_q    <= obs_on_d;
      collision_q <= collision_d;
    end
  end

  assign obs_on    = obs_on_q;
  assign collision = collision_q;
  assign lane_y    = lane_y_q;

endmodule

// File: tb/tb_obstacle_lane.sv
// tb_obstacle_lane: directed bench for obstacle_lane.
// The driver issues stimulus and queues the expected values for each edge.
// A negedge monitor pops the queued expectations and compares them.
module tb_obstacle_lane;

  logic       clk = 1'b0;
  logic       reset, move_followers, game_run, frame_tick;
  logic [9:0] pix_x, pix_y, player_x, player_y;
  logic       obs_on, collision;
  logic [9:0] lane_y;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Selectors for the observed quantity
  localparam int S_OBS = 0, S_COL = 1, S_LANE = 2, S_CAR = 3, S_SPD = 4, S_DIR = 5, S_ST = 6;

  logic [10:0] exp_q[$];
  int          sel_q[$];
  int          due_q[$];
  string       tag_q[$];

  logic [7:0]  m_lfsr;

  obstacle_lane dut (
    .clk(clk), .reset(reset), .move_followers(move_followers), .game_run(game_run),
    .frame_tick(frame_tick), .pix_x(pix_x), .pix_y(pix_y), .player_x(player_x),
    .player_y(player_y), .obs_on(obs_on), .collision(collision), .lane_y(lane_y)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Reference 8-bit Fibonacci LFSR, taps 8,6,5,4, seeded with 8'hA5
  always @(posedge clk) m_lfsr <= reset ? 8'hA5 : lfsr_next(m_lfsr);

  // ---------------- scoreboard ----------------
  function automatic logic [10:0] actual(input int sel);
    case (sel)
      S_OBS:   return {10'd0, obs_on};
      S_COL:   return {10'd0, collision};
      S_LANE:  return {1'b0, lane_y};
      S_CAR:   return {1'b0, dut.car_x_q};
      S_SPD:   return {8'd0, dut.speed_q};
      S_DIR:   return {10'd0, dut.dir_q};
      default: return {9'd0, dut.state_q};
    endcase
  endfunction

  task automatic push_exp(input string tag, input int sel, input logic [10:0] v);
    exp_q.push_back(v);
    sel_q.push_back(sel);
    due_q.push_back(cyc);
    tag_q.push_back(tag);
  endtask

  // Monitor: compare every expectation that is due at this negedge
  always @(negedge clk) begin
    while (due_q.size() > 0 && due_q[0] <= cyc) begin
      logic [10:0] e, a;
      string t;
      e = exp_q.pop_front();
      a = actual(sel_q.pop_front());
      t = tag_q.pop_front();
      void'(due_q.pop_front());
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", t, a, e, cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic pulse_n(input int n);
    for (int i = 0; i < n; i++) begin
      move_followers = 1'b1;
      step();
      move_followers = 1'b0;
      step();
    end
  endtask

  task automatic exp_reset_vals(input string tag);
    push_exp({tag, "_lane"}, S_LANE, 11'd150);
    push_exp({tag, "_obs"},  S_OBS,  11'd0);
    push_exp({tag, "_col"},  S_COL,  11'd0);
    push_exp({tag, "_st"},   S_ST,   11'd0);
    push_exp({tag, "_car"},  S_CAR,  11'd0);
    push_exp({tag, "_spd"},  S_SPD,  11'd1);
    push_exp({tag, "_dir"},  S_DIR,  11'd0);
  endtask

  // Wait until the LFSR value sampled at the coming respawn has the wanted
  // low three bits. The wrap happens on the next edge, and the respawn reads
  // the LFSR value that follows it.
  task automatic wait_lfsr(input logic [2:0] target);
    logic [7:0] nxt;
    int w;
    w = 0;
    nxt = lfsr_next(m_lfsr);
    while (nxt[2:0] != target && w < 300) begin
      step();
      w++;
      nxt = lfsr_next(m_lfsr);
    end
    if (w >= 300) begin
      n_cmp++;
      n_fail++;
      $display("FAIL lfsr_wait: got no match expected low bits %0d", target);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; game_run = 1'b0; move_followers = 1'b0; frame_tick = 1'b0;
    pix_x = 10'd0; pix_y = 10'd0; player_x = 10'd0; player_y = 10'd400;
    step();
    step();
    exp_reset_vals("reset");

    // IDLE forces obs_on low even with the beam inside the car
    reset = 1'b0; pix_x = 10'd10; pix_y = 10'd150;
    step();
    push_exp("idle_obs", S_OBS, 11'd0);
    push_exp("idle_st",  S_ST,  11'd0);
    game_run = 1'b1;
    step();
    push_exp("to_run", S_ST, 11'd1);
    step();
    push_exp("run_obs", S_OBS, 11'd1);

    // Speed 1, rightwards: 200 frames put the car at column 200
    tick_n(200);
    push_exp("car200", S_CAR, 11'd200);

    // Pixel sweep across the car's columns, one cycle of latency
    for (int x = 199; x <= 232; x++) begin
      pix_x = 10'(x); pix_y = 10'd150;
      step();
      push_exp($sformatf("sweep_x%0d", x), S_OBS, (x >= 200 && x <= 231) ? 11'd1 : 11'd0);
    end
    pix_x = 10'd210; pix_y = 10'd165; step(); push_exp("row165", S_OBS, 11'd1);
    pix_y = 10'd166; step(); push_exp("row166", S_OBS, 11'd0);
    pix_y = 10'd149; step(); push_exp("row149", S_OBS, 11'd0);

    // Scroll and frame step in the same cycle
    move_followers = 1'b1; frame_tick = 1'b1;
    step();
    move_followers = 1'b0; frame_tick = 1'b0;
    push_exp("both_lane", S_LANE, 11'd152);
    push_exp("both_car",  S_CAR,  11'd201);

    // Near miss on x: player_x equals car_x + CAR_W
    player_x = 10'd233; player_y = 10'd152;
    tick_n(1);
    push_exp("miss_x_col", S_COL, 11'd0);
    push_exp("miss_x_st",  S_ST,  11'd1);
    push_exp("miss_x_car", S_CAR, 11'd202);
    // Near miss on y: player_y equals lane_y + CAR_H
    player_x = 10'd202; player_y = 10'd168;
    tick_n(1);
    push_exp("miss_y_col", S_COL, 11'd0);
    push_exp("miss_y_car", S_CAR, 11'd203);
    // Real overlap with car at 203
    player_x = 10'd234; player_y = 10'd152;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    push_exp("hit_col", S_COL, 11'd1);
    push_exp("hit_st",  S_ST,  11'd2);
    push_exp("hit_car", S_CAR, 11'd204);

    // HIT freezes all motion
    move_followers = 1'b1; frame_tick = 1'b1;
    step();
    move_followers = 1'b0; frame_tick = 1'b0;
    push_exp("frz_lane", S_LANE, 11'd152);
    push_exp("frz_car",  S_CAR,  11'd204);
    push_exp("frz_col",  S_COL,  11'd1);
    game_run = 1'b0;
    step();
    push_exp("frz_st", S_ST, 11'd2);

    // Reset while in HIT
    reset = 1'b1;
    step();
    exp_reset_vals("rst_hit");
    reset = 1'b0; player_x = 10'd0; player_y = 10'd400; game_run = 1'b1;
    step();
    push_exp("rerun_st", S_ST, 11'd1);

    // Scroll run: 164 pulses reach 478, the 165th wraps, 240 in all return to 150
    move_followers = 1'b1;
    step();
    move_followers = 1'b0;
    push_exp("lane_p1", S_LANE, 11'd152);
    step();
    pulse_n(163);
    push_exp("lane_p164", S_LANE, 11'd478);
    wait_lfsr(3'b010);
    move_followers = 1'b1;
    step();
    move_followers = 1'b0;
    push_exp("lane_wrap", S_LANE, 11'd0);
    step();
    push_exp("rsp1_spd", S_SPD, 11'd3);
    push_exp("rsp1_dir", S_DIR, 11'd0);
    push_exp("rsp1_car", S_CAR, 11'd0);
    pulse_n(75);
    push_exp("lane_p240", S_LANE, 11'd150);
    push_exp("once_spd",  S_SPD,  11'd3);
    push_exp("once_dir",  S_DIR,  11'd0);

    // Rightward wrap at speed 3
    tick_n(212);
    push_exp("r_636", S_CAR, 11'd636);
    tick_n(1);
    push_exp("r_639", S_CAR, 11'd639);
    tick_n(1);
    push_exp("r_wrap", S_CAR, 11'd2);

    // Second wrap; choose a respawn going left at speed 4
    pulse_n(164);
    push_exp("lane2_p164", S_LANE, 11'd478);
    wait_lfsr(3'b111);
    move_followers = 1'b1;
    step();
    move_followers = 1'b0;
    push_exp("lane2_wrap", S_LANE, 11'd0);
    step();
    push_exp("rsp2_spd", S_SPD, 11'd4);
    push_exp("rsp2_dir", S_DIR, 11'd1);
    push_exp("rsp2_car", S_CAR, 11'd608);

    // Leftward motion and wrap at speed 4
    tick_n(151);
    push_exp("l_4", S_CAR, 11'd4);
    tick_n(1);
    push_exp("l_0", S_CAR, 11'd0);
    tick_n(1);
    push_exp("l_wrap", S_CAR, 11'd636);

    // Dropping game_run returns to IDLE
    game_run = 1'b0; pix_x = 10'd2; pix_y = 10'd5;
    step();
    push_exp("idle_again", S_ST, 11'd0);
    step();
    push_exp("idle_obs2", S_OBS, 11'd0);

    step();
    step();
    if (exp_q.size() != 0) begin
      n_cmp += exp_q.size();
      n_fail += exp_q.size();
      $display("FAIL drain: got %0d unchecked expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog: the run must finish within a fixed time
  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/obstacle_lane.md
Name: obstacle_lane

Overview:
- One horizontal car lane in the crossy-road playfield.
- Sits directly downstream of the vertical scroll stage:
  - consumes its one-cycle `move_followers` pulse to scroll the lane down in lock-step with the world;
  - moves the car horizontally once per video frame.
- Produces a registered pixel-hit signal for the VGA mixer and a sticky player-collision flag for the game controller.

Parameters:
- Y_OFFSET, 150, lane top row after reset
- MOVE_AMT, 2, rows added per move_followers pulse
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in rows
- CAR_W, 32, car width in pixels
- CAR_H, 16, car height in rows
- PLAYER_SZ, 16, player square side in pixels
- LFSR_SEED, 8'hA5, nonzero LFSR reset value

Ports:
- clk  in  1  system clock, 25 MHz pixel clock
- reset  in  1  synchronous, active-high
- move_followers  in  1  one-cycle scroll pulse from upstream scroll stage
- game_run  in  1  level; high while game is active
- frame_tick  in  1  one-cycle pulse, first cycle of vertical blank
- pix_x  in  10  current beam column
- pix_y  in  10  current beam row
- player_x  in  10  player left column
- player_y  in  10  player top row
- obs_on  out  1  registered; beam is inside a car
- collision  out  1  sticky player-car overlap flag
- lane_y  out  10  current lane top row

Behaviour:
- Reset values:
  - lane_y=Y_OFFSET, car_x=0, dir=0 (right), speed=1
  - lfsr=LFSR_SEED, state=IDLE, obs_on=0, collision=0
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4.
  - Shifts every cycle, independent of state.
  - Never zero.
- States:
  - IDLE: nothing moves. Go to RUN when game_run=1.
  - RUN: scrolling and horizontal motion active. Go to HIT on collision. Go to IDLE if game_run=0.
  - HIT: all motion frozen; collision held at 1. Leave only via reset.
- Scroll (RUN only, move_followers=1):
  - If lane_y+MOVE_AMT >= SCREEN_H: lane_y<=0, then respawn.
  - Otherwise lane_y<=lane_y+MOVE_AMT.
  - Arithmetic is 11-bit to avoid overflow.
- Respawn:
  - speed<=lfsr[1:0]+1 (range 1..4).
  - dir<=lfsr[2].
  - car_x<=0 if dir=0, else SCREEN_W-CAR_W.
  - Takes effect the cycle after the wrap.
- Horizontal motion (RUN only, frame_tick=1):
  - Right: if car_x+speed >= SCREEN_W then car_x<=car_x+speed-SCREEN_W, else car_x+speed.
  - Left: if car_x < speed then car_x<=car_x+SCREEN_W-speed, else car_x-speed.
- Simultaneous move_followers and frame_tick: both updates apply in the same cycle, to independent registers.
- Collision check (RUN only, on frame_tick):
  - Boxes overlap iff player_x < car_x+CAR_W, car_x < player_x+PLAYER_SZ, player_y < lane_y+CAR_H, lane_y < player_y+PLAYER_SZ.
  - Uses pre-update car_x/lane_y.
  - On overlap: collision<=1 and state<=HIT on the next edge.
- obs_on:
  - Set when pix_x in [car_x, car_x+CAR_W) and pix_y in [lane_y, lane_y+CAR_H).
  - One-cycle latency from pix_x/pix_y.
  - Forced 0 in IDLE.
  - A car straddling the right edge is not drawn wrapped; its off-screen part is clipped.
- Reset mid-operation: all registers return to reset values on the next edge, regardless of state.

Optional Feature:
- Macro: OBSTACLE_TWO_CARS_EN.
- Defined:
  - A second car is placed at (car_x+SCREEN_W/2) mod SCREEN_W.
  - It shares lane_y, dir and speed.
  - obs_on is the OR of both cars.
  - Collision checks both cars.
- Undefined:
  - Single car only.
  - No second-car logic is synthesized.

Test Plan:
- Reset, game_run=1, 240 move_followers pulses -> lane_y goes 150→478 after 164 pulses, wraps to 0 on pulse 165, equals 150 after pulse 240; speed/dir reload exactly once.
- RUN, dir=0, speed=3, car_x=638, one frame_tick -> car_x=1.
- dir=1, speed=4, car_x=2, one frame_tick -> car_x=638.
- player (100,150), car_x=90, lane_y=150, frame_tick -> collision=1 next cycle, state HIT; further move_followers/frame_tick leave lane_y and car_x unchanged.
- car_x=200, lane_y=150; sweep pix (199..232, 150) -> obs_on high exactly for inputs 200..231, observed one cycle later; pix_y=166 -> 0.
- move_followers and frame_tick asserted in the same cycle -> lane_y+2 and car_x+speed both applied. Reset asserted while in HIT -> all outputs return to reset values next edge.
